button_event_decoder: RTL and testbench

Consumes the clean, clock-synchronous push-button events produced by the debouncer and turns them into user-interface gestures for the VGA front end: single click, double click, long-press start, and auto-repeat ticks while the button is held. All timing is counted in clock cycles. Outputs are registered one-cycle pulses, plus a held level, for the cursor/menu logic.

---
 rtl/button_pkg.sv | 20 ++
 rtl/btn_timer.sv | 42 ++++
 rtl/button_event_decoder.sv | 151 +++++++++++++++
 tb/tb_button_event_decoder.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared definitions for the push-button gesture decoder.
//   - btn_state_e : decoder FSM states
//   - *_DEF       : default gesture thresholds in clock cycles (25 MHz clock)
//   - CNT_W       : default gesture timer width
package button_pkg;

    localparam int CNT_W             = 24;
    localparam int LONG_CYCLES_DEF   = 12_500_000;  // 0.5 s
    localparam int REPEAT_CYCLES_DEF = 2_500_000;   // 100 ms
    localparam int DCLICK_CYCLES_DEF = 7_500_000;   // 300 ms

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD,
        WAIT_SECOND,
        SECOND_PRESSED
    } btn_state_e;

endpackage

// File: rtl/btn_timer.sv
// Gesture timer: CNT_W-bit up-counter with synchronous clear and count enable.
// term flags the last cycle of a period, i.e. count == thresh - 1.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (takes priority over en)
//   en         : count enable
//   thresh     : period length in cycles, selected at run time by the caller
//   term       : count has reached thresh - 1
module btn_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] thresh,
    output logic             term
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term = (cnt_q == thresh - CNT_W'(1));

endmodule

// File: rtl/button_event_decoder.sv
// Turns debounced press/release pulses into UI gestures: single click,
// double click, long-press start and auto-repeat ticks while long-held.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   pb_down     : one-cycle pulse, button pressed
//   pb_up       : one-cycle pulse, button released
//   click       : pulse, single short click confirmed
//   dbl_click   : pulse, double click
//   long_start  : pulse, press crossed LONG_CYCLES
//   repeat_tick : pulse every REPEAT_CYCLES while long-held
//   held        : level, decoder considers the button down
// All outputs are registered; pulses appear the cycle after the decision.
module button_event_decoder #(
    parameter int LONG_CYCLES   = button_pkg::LONG_CYCLES_DEF,
    parameter int REPEAT_CYCLES = button_pkg::REPEAT_CYCLES_DEF,
    parameter int DCLICK_CYCLES = button_pkg::DCLICK_CYCLES_DEF,
    parameter int CNT_W         = button_pkg::CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb_down,
    input  logic pb_up,
    output logic click,
    output logic dbl_click,
    output logic long_start,
    output logic repeat_tick,
    output logic held
);

    import button_pkg::*;

    btn_state_e       state_q, state_d;
    logic             click_q, click_d;
    logic             dbl_click_q, dbl_click_d;
    logic             long_start_q, long_start_d;
    logic             repeat_tick_q, repeat_tick_d;
    logic             held_q, held_d;

    logic             tmr_clr;
    logic             tmr_en;
    logic             tmr_term;
    logic             rep_clr;
    logic [CNT_W-1:0] tmr_thresh;

    // Simultaneous press and release is contradictory; treat it as no edge.
    logic dn, up;
    assign dn = pb_down & ~pb_up;
    assign up = pb_up & ~pb_down;

    always_comb begin
        unique case (state_q)
            LONG_HELD:   tmr_thresh = CNT_W'(REPEAT_CYCLES);
            WAIT_SECOND: tmr_thresh = CNT_W'(DCLICK_CYCLES);
            default:     tmr_thresh = CNT_W'(LONG_CYCLES);
        endcase
    end

    btn_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .thresh (tmr_thresh),
        .term   (tmr_term)
    );

    always_comb begin
        state_d       = state_q;
        click_d       = 1'b0;
        dbl_click_d   = 1'b0;
        long_start_d  = 1'b0;
        repeat_tick_d = 1'b0;
        rep_clr       = 1'b0;

        // Releases/presses are checked before the terminal count so that a
        // user edge landing on the terminal cycle always wins.
        unique case (state_q)
            IDLE: begin
                // A release here belongs to a press made before reset.
                if (dn) state_d = PRESSED;
            end
            PRESSED: begin
                if (up) begin
                    state_d = WAIT_SECOND;
                end else if (tmr_term) begin
                    state_d      = LONG_HELD;
                    long_start_d = 1'b1;
                end
            end
            LONG_HELD: begin
                if (up) begin
                    state_d = IDLE;
                end else if (tmr_term) begin
                    repeat_tick_d = 1'b1;
                    rep_clr       = 1'b1;
                end
            end
            WAIT_SECOND: begin
                if (dn) begin
                    state_d = SECOND_PRESSED;
                end else if (tmr_term) begin
                    state_d = IDLE;
                    click_d = 1'b1;
                end
            end
            SECOND_PRESSED: begin
                if (up) begin
                    state_d     = IDLE;
                    dbl_click_d = 1'b1;
                end else if (tmr_term) begin
                    // First press was a click; the second became a long press.
                    state_d      = LONG_HELD;
                    click_d      = 1'b1;
                    long_start_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        held_d = (state_q == PRESSED) || (state_q == LONG_HELD) ||
                 (state_q == SECOND_PRESSED);
    end

    assign tmr_clr = rep_clr || (state_d != state_q);
    assign tmr_en  = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            click_q       <= 1'b0;
            dbl_click_q   <= 1'b0;
            long_start_q  <= 1'b0;
            repeat_tick_q <= 1'b0;
            held_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            click_q       <= click_d;
            dbl_click_q   <= dbl_click_d;
            long_start_q  <= long_start_d;
            repeat_tick_q <= repeat_tick_d;
            held_q        <= held_d;
        end
    end

    assign click       = click_q;
    assign dbl_click   = dbl_click_q;
    assign long_start  = long_start_q;
    assign repeat_tick = repeat_tick_q;
    assign held        = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder with short thresholds (LONG=20, REPEAT=5,
// DCLICK=10). Cycle t0 of a gesture is the first cycle after the pb_down
// pulse. Expected pulses are queued as (cycle, kind) when stimulus is
// scheduled and matched by a monitor as the DUT emits them.
module tb_button_event_decoder;

    localparam int LONG_C   = 20;
    localparam int REPEAT_C = 5;
    localparam int DCLICK_C = 10;

    localparam int K_CLICK = 0;
    localparam int K_DBL   = 1;
    localparam int K_LONG  = 2;
    localparam int K_REP   = 3;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pb_down = 1'b0;
    logic pb_up = 1'b0;
    logic click, dbl_click, long_start, repeat_tick, held;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  sb[$];
    logic [3:0] mon_v;
    ev_t  mon_e;

    button_event_decoder #(
        .LONG_CYCLES   (LONG_C),
        .REPEAT_CYCLES (REPEAT_C),
        .DCLICK_CYCLES (DCLICK_C),
        .CNT_W         (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pb_down     (pb_down),
        .pb_up       (pb_up),
        .click       (click),
        .dbl_click   (dbl_click),
        .long_start  (long_start),
        .repeat_tick (repeat_tick),
        .held        (held)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_CLICK: return "click";
            K_DBL:   return "dbl_click";
            K_LONG:  return "long_start";
            default: return "repeat_tick";
        endcase
    endfunction

    // Scoreboard monitor: every pulse seen must match the head of the queue.
    always @(negedge clk) begin
        mon_v = {repeat_tick, long_start, dbl_click, click};
        for (int k = 0; k < 4; k++) begin
            if (mon_v[k] === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL pulse_unexpected: got %s at cycle %0d, want no pulse",
                             kname(k), cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.kind != k || mon_e.cyc != cyc) begin
                        errors++;
                        $display("FAIL pulse_match: got %s at cycle %0d, want %s at cycle %0d",
                                 kname(k), cyc, kname(mon_e.kind), mon_e.cyc);
                    end
                end
            end
        end
    end

    // Drive one cycle of inputs, sampled at the next rising edge.
    task automatic cyc_step(input logic dn, input logic up);
        pb_down = dn;
        pb_up   = up;
        @(posedge clk);
        #1;
        pb_down = 1'b0;
        pb_up   = 1'b0;
    endtask

    task automatic idle_to(input int c);
        while (cyc < c) cyc_step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({click, dbl_click, long_start, repeat_tick, held} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, want 00000",
                     {click, dbl_click, long_start, repeat_tick, held});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_to(cyc + 3);
    endtask

    task automatic test_single_click();
        int   t0;
        logic exp_h;
        t0 = cyc + 1;
        sb.push_back('{t0 + 16, K_CLICK});
        cyc_step(1'b1, 1'b0);
        while (cyc < t0 + 30) begin
            pb_up = (cyc == t0 + 5);
            @(negedge clk);
            exp_h = (cyc >= t0 + 1) && (cyc <= t0 + 6);
            checks++;
            if (held !== exp_h) begin
                errors++;
                $display("FAIL held_click: cycle %0d got %b want %b", cyc - t0, held, exp_h);
            end
            @(posedge clk);
            #1;
            pb_up = 1'b0;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL single_click_missing: %0d pulses outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_double_click();
        int t0;
        t0 = cyc + 1;
        sb.push_back('{t0 + 11, K_DBL});
        cyc_step(1'b1, 1'b0);
        idle_to(t0 + 3);  cyc_step(1'b0, 1'b1);
        idle_to(t0 + 7);  cyc_step(1'b1, 1'b0);
        idle_to(t0 + 10); cyc_step(1'b0, 1'b1);
        idle_to(t0 + 30);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL double_click_missing: %0d pulses outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_long_repeat();
        int t0;
        t0 = cyc + 1;
        sb.push_back('{t0 + 20, K_LONG});
        sb.push_back('{t0 + 25, K_REP});
        sb.push_back('{t0 + 30, K_REP});
        sb.push_back('{t0 + 35, K_REP});
        cyc_step(1'b1, 1'b0);
        idle_to(t0 + 37);
        cyc_step(1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (held !== 1'b1) begin
            errors++;
            $display("FAIL held_long_last: cycle %0d got %b want 1", cyc - t0, held);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (held !== 1'b0) begin
            errors++;
            $display("FAIL held_long_fall: cycle %0d got %b want 0", cyc - t0, held);
        end
        @(posedge clk);
        #1;
        idle_to(t0 + 60);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL long_repeat_missing: %0d pulses outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_edge_on_terminal();
        int t0;
        // Release on the long-press terminal cycle: stays a short press.
        t0 = cyc + 1;
        sb.push_back('{t0 + 30, K_CLICK});
        cyc_step(1'b1, 1'b0);
        idle_to(t0 + 19); cyc_step(1'b0, 1'b1);
        idle_to(t0 + 45);
        // Second press on the double-click terminal cycle: becomes dbl_click.
        t0 = cyc + 1;
        sb.push_back('{t0 + 17, K_DBL});
        cyc_step(1'b1, 1'b0);
        idle_to(t0 + 3);  cyc_step(1'b0, 1'b1);
        idle_to(t0 + 13); cyc_step(1'b1, 1'b0);
        idle_to(t0 + 16); cyc_step(1'b0, 1'b1);
        idle_to(t0 + 40);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL terminal_edges_missing: %0d pulses outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_second_long();
        int t0;
        t0 = cyc + 1;
        sb.push_back('{t0 + 26, K_CLICK});
        sb.push_back('{t0 + 26, K_LONG});
        cyc_step(1'b1, 1'b0);
        idle_to(t0 + 3);  cyc_step(1'b0, 1'b1);
        idle_to(t0 + 5);  cyc_step(1'b1, 1'b0);
        idle_to(t0 + 28); cyc_step(1'b0, 1'b1);
        idle_to(t0 + 50);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL second_long_missing: %0d pulses outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        int tend;
        t0 = cyc + 1;
        sb.push_back('{t0 + 20, K_LONG});
        cyc_step(1'b1, 1'b0);
        idle_to(t0 + 22);
        checks++;
        if (held !== 1'b1) begin
            errors++;
            $display("FAIL held_before_reset: got %b want 1", held);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({click, dbl_click, long_start, repeat_tick, held} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %b want 00000",
                     {click, dbl_click, long_start, repeat_tick, held});
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc_step(1'b0, 1'b1);
        tend = cyc + 30;
        while (cyc < tend) begin
            @(negedge clk);
            checks++;
            if (held !== 1'b0) begin
                errors++;
                $display("FAIL held_after_reset: cycle %0d got %b want 0", cyc, held);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_missing: %0d pulses outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_illegal_both();
        int t0;
        cyc_step(1'b1, 1'b1);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (held !== 1'b0) begin
                errors++;
                $display("FAIL held_idle_both: got %b want 0", held);
            end
            @(posedge clk);
            #1;
        end
        t0 = cyc + 1;
        sb.push_back('{t0 + 16, K_CLICK});
        cyc_step(1'b1, 1'b0);
        idle_to(t0 + 2);
        cyc_step(1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (held !== 1'b1) begin
            errors++;
            $display("FAIL held_pressed_both: got %b want 1", held);
        end
        @(posedge clk);
        #1;
        idle_to(t0 + 5); cyc_step(1'b0, 1'b1);
        idle_to(t0 + 30);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL illegal_both_missing: %0d pulses outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_single_click();
        test_double_click();
        test_long_repeat();
        test_edge_on_terminal();
        test_second_long();
        test_reset_mid();
        test_illegal_both();
        idle_to(cyc + 5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
